// File: rtl/v_act_scheduler.sv
// v_act_scheduler: round-robin sharing of one activation unit across NumReq vector producers (optional back-to-back grants: V_ACT_SCHED_B2B_EN)
module v_act_scheduler #(
  parameter int NumReq      = 4,
  parameter int InVecLength = 64,
  parameter int WorkingRegs = 8,
  parameter int NBits       = 8
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic [NumReq-1:0]                            req_valid_in,
  input  logic [NumReq-1:0][WorkingRegs-1:0][NBits-1:0] req_data_in,
  output logic [NumReq-1:0]                            req_pop_out,
  output logic [WorkingRegs-1:0][NBits-1:0]            act_data_out,
  input  logic [WorkingRegs-1:0][NBits-1:0]            act_result_in,
  output logic [WorkingRegs-1:0][NBits-1:0]            out_data_out,
  output logic                                         out_valid_out,
  input  logic                                         out_ready_in,
  output logic                                         out_last_out,
  output logic [$clog2(NumReq)-1:0]                    out_tag_out,
  output logic                                         busy_out
);
  localparam int ChunksPerVec = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int CntW         = $clog2(ChunksPerVec) + 1;
  localparam int TagW         = $clog2(NumReq);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            r_state, w_next_state;
  logic [TagW-1:0]   r_grant_id, w_next_grant, r_rr_ptr, w_next_rr, w_win_id, w_idx;
  logic [CntW-1:0]   r_chunk_cnt, w_next_cnt;
  logic [NumReq-1:0] w_own, w_cand;
  logic              w_busy, w_win_found, w_accept, w_last;
  assign w_busy = r_state == BURST;
  assign w_own  = w_busy ? NumReq'(1) << r_grant_id : '0;
  assign w_cand = req_valid_in & ~w_own;
  assign w_last = r_chunk_cnt == CntW'(ChunksPerVec - 1);
  // Round-robin pick: first candidate scanning upward from rr_ptr+1; the owner is masked so a retiring vector hands over
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int i = NumReq; i >= 1; i--) begin
      w_idx = TagW'((int'(r_rr_ptr) + i) % NumReq);
      if (w_cand[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end
  // Next state and outputs: datapath muxes are purely combinational so the result lands in the accepting cycle
  always_comb begin
    w_next_state  = r_state;
    w_next_grant  = r_grant_id;
    w_next_rr     = r_rr_ptr;
    w_next_cnt    = r_chunk_cnt;
    busy_out      = w_busy;
    out_valid_out = w_busy;
    out_tag_out   = w_busy ? r_grant_id : '0;
    act_data_out  = w_busy ? req_data_in[r_grant_id] : '0;
    out_data_out  = w_busy ? act_result_in : '0;
    w_accept      = w_busy & out_ready_in;
    out_last_out  = w_busy & w_last;
    req_pop_out   = w_accept ? w_own : '0;
    if (!w_busy) begin
      if (w_win_found) begin
        w_next_state = BURST;
        w_next_grant = w_win_id;
        w_next_rr    = w_win_id;
        w_next_cnt   = '0;
      end
    end else if (w_accept) begin
      w_next_cnt = w_last ? '0 : r_chunk_cnt + 1'b1;
      if (w_last) begin
`ifdef V_ACT_SCHED_B2B_EN
        if (w_win_found) begin
          w_next_grant = w_win_id;
          w_next_rr    = w_win_id;
        end else begin
          w_next_state = IDLE;
        end
`else
        w_next_state = IDLE;
`endif
      end
    end
  end
  // State register; rr_ptr resets to the top id so producer 0 wins first
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= TagW'(NumReq - 1);
      r_chunk_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_grant_id  <= w_next_grant;
      r_rr_ptr    <= w_next_rr;
      r_chunk_cnt <= w_next_cnt;
    end
  end
endmodule

// File: tb/tb_v_act_scheduler.sv
// tb_v_act_scheduler: directed checks of arbitration, streaming, stalls, short vectors and async reset
module tb_v_act_scheduler;
  localparam int CPV = 8;
`ifdef V_ACT_SCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rdy;
  always #5 clk = ~clk;
  logic [3:0] en_a, pop_a, en_b, pop_b, en_c, pop_c;
  logic [3:0][7:0][7:0] rd_a, rd_z;
  logic [7:0][7:0] act_a, res_a, out_a, act_b, out_b, act_c, out_c, res_z;
  logic v_a, l_a, busy_a, v_b, l_b, busy_b, v_c, l_c, busy_c;
  logic [1:0] tag_a, tag_b, tag_c;
  int popcnt [4] = '{default: 0};
  int exp_idx [4] = '{default: 0};
  int n_chk = 0, n_err = 0;
  assign rd_z  = '0;
  assign res_z = '0;
  function automatic logic [7:0] f(input int p, input int c, input int l);
    return l == 0 ? 8'h80 : l == 1 ? 8'd5 : 8'(p * 16 + c * 2 + l);
  endfunction
  function automatic logic [7:0] leaky(input logic [7:0] x);
    return x[7] ? 8'($signed(x) >>> 7) : x;
  endfunction
  function automatic logic [63:0] exp_chunk(input int p, input int c);
    logic [63:0] v = '0;
    for (int l = 7; l >= 0; l--) v = {v[55:0], leaky(f(p, c, l))};
    return v;
  endfunction
  always_comb begin
    for (int p = 0; p < 4; p++)
      for (int l = 0; l < 8; l++) rd_a[2'(p)][3'(l)] = f(p, popcnt[2'(p)], l);
    for (int l = 0; l < 8; l++) res_a[3'(l)] = leaky(act_a[3'(l)]);
  end
  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (pop_a[2'(i)]) popcnt[2'(i)] <= popcnt[2'(i)] + 1;
  v_act_scheduler dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(en_a), .req_data_in(rd_a), .req_pop_out(pop_a),
    .act_data_out(act_a), .act_result_in(res_a), .out_data_out(out_a), .out_valid_out(v_a),
    .out_ready_in(rdy), .out_last_out(l_a), .out_tag_out(tag_a), .busy_out(busy_a));
  v_act_scheduler #(.InVecLength(20)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(en_b), .req_data_in(rd_z), .req_pop_out(pop_b),
    .act_data_out(act_b), .act_result_in(res_z), .out_data_out(out_b), .out_valid_out(v_b),
    .out_ready_in(1'b1), .out_last_out(l_b), .out_tag_out(tag_b), .busy_out(busy_b));
  v_act_scheduler #(.InVecLength(8)) dut_c (
    .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(en_c), .req_data_in(rd_z), .req_pop_out(pop_c),
    .act_data_out(act_c), .act_result_in(res_z), .out_data_out(out_c), .out_valid_out(v_c),
    .out_ready_in(1'b1), .out_last_out(l_c), .out_tag_out(tag_c), .busy_out(busy_c));
  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask
  task automatic check_zero(input string t);
    check({t, "_pop"}, 64'(pop_a), 0);
    check({t, "_valid"}, 64'(v_a), 0);
    check({t, "_last"}, 64'(l_a), 0);
    check({t, "_busy"}, 64'(busy_a), 0);
    check({t, "_tag"}, 64'(tag_a), 0);
    check({t, "_act"}, 64'(act_a), 0);
    check({t, "_out"}, 64'(out_a), 0);
  endtask
  task automatic req_a(input logic [3:0] m);
    @(negedge clk);
    en_a = m;
    rdy = 1'b1;
    #1;
    check("lat0_valid", 64'(v_a), 0);
  endtask
  task automatic vec_a(input int p, input logic [31:0] stall);
    int acc = 0;
    for (int c = 0; c < 24 && acc < CPV; c++) begin
      @(negedge clk);
      en_a = '0;
      rdy = ~stall[5'(c)];
      #1;
      check($sformatf("v%0d_valid", p), 64'(v_a), 1);
      check($sformatf("v%0d_busy", p), 64'(busy_a), 1);
      check($sformatf("v%0d_tag", p), 64'(tag_a), 64'(p));
      check($sformatf("v%0d_pop", p), 64'(pop_a), 64'(rdy ? 4'(1 << p) : 4'd0));
      check($sformatf("v%0d_last", p), 64'(l_a), 64'(acc == CPV - 1));
      check($sformatf("v%0d_data", p), 64'(out_a), exp_chunk(p, exp_idx[2'(p)]));
      if (rdy) begin
        acc++;
        exp_idx[2'(p)]++;
      end
    end
    check($sformatf("v%0d_beats", p), 64'(acc), CPV);
    @(negedge clk);
    rdy = 1'b1;
    #1;
    check($sformatf("v%0d_idle_after", p), 64'(v_a), 0);
  endtask
  initial begin
    int starts, bub, vec;
    logic inv, done;
    en_a = '0;
    en_b = '0;
    en_c = '0;
    rdy = 1'b1;
    @(negedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    req_a(4'b0100);
    vec_a(2, 0);
    req_a(4'b0010);
    vec_a(1, 32'b11100);
    req_a(4'b1000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en_a = '0;
      rdy = 1'b1;
      #1;
      check("p3_pop", 64'(pop_a), 64'(4'b1000));
      exp_idx[2'd3]++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    en_a = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_idle", 64'(v_a), 0);
    vec_a(0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    en_a = 4'hF;
    starts = 0;
    bub = 0;
    vec = -1;
    inv = 1'b0;
    for (int c = 0; c < 120 && starts < 5; c++) begin
      @(negedge clk);
      #1;
      if (v_a) begin
        if (!inv) begin
          inv = 1'b1;
          vec++;
          starts++;
          if (starts == 5) en_a = '0;
        end
        check("rr_tag", 64'(tag_a), 64'(vec % 4));
        check("rr_data", 64'(out_a), exp_chunk(vec % 4, exp_idx[2'(vec % 4)]));
        exp_idx[2'(vec % 4)]++;
        if (l_a) inv = 1'b0;
      end else if (starts > 0) bub++;
    end
    check("rr_starts", 64'(starts), 5);
    check("rr_bubbles", 64'(bub), B2B ? 64'd0 : 64'd4);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      #1;
      check("drain_tag", 64'(tag_a), 0);
      check("drain_data", 64'(out_a), exp_chunk(0, exp_idx[2'd0]));
      exp_idx[2'd0]++;
      if (l_a) done = 1'b1;
    end
    check("drain_done", 64'(done), 1);
    @(negedge clk);
    #1;
    check("drain_idle", 64'(v_a), 0);
    @(negedge clk);
    en_b = 4'b0001;
    en_c = 4'b0001;
    #1;
    check("short_lat0", 64'({v_b, v_c}), 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      en_b = '0;
      en_c = '0;
      #1;
      check($sformatf("b%0d_valid", k), 64'(v_b), 64'(k <= 3));
      check($sformatf("b%0d_busy", k), 64'(busy_b), 64'(k <= 3));
      check($sformatf("b%0d_last", k), 64'(l_b), 64'(k == 3));
      check($sformatf("b%0d_pop", k), 64'(pop_b), 64'(k <= 3 ? 4'b0001 : 4'b0000));
      check($sformatf("b%0d_misc", k), 64'({tag_b, act_b, out_b}), 0);
      check($sformatf("c%0d_valid", k), 64'(v_c), 64'(k == 1));
      check($sformatf("c%0d_busy", k), 64'(busy_c), 64'(k == 1));
      check($sformatf("c%0d_last", k), 64'(l_c), 64'(k == 1));
      check($sformatf("c%0d_pop", k), 64'(pop_c), 64'(k == 1 ? 4'b0001 : 4'b0000));
      check($sformatf("c%0d_misc", k), 64'({tag_c, act_c, out_c}), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/v_act_scheduler.md
Name: v_act_scheduler

Overview:
- Round-robin scheduler that shares one combinational elementwise activation unit (v_leakyrelu-class datapath) between NumReq vector producers.
- Grants the unit for one whole vector at a time, streamed as ceil(InVecLength/WorkingRegs) chunks.
- Pops the granted producer's show-ahead FIFO one chunk per accepted beat.
- Forwards activated chunks to a single downstream sink, tagged with the source id and an end-of-vector marker.

Parameters:
- NumReq, 4, number of requesting producers (>=2).
- InVecLength, 64, elements per vector.
- WorkingRegs, 8, elements per chunk (datapath width).
- NBits, 8, bits per signed element.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- req_valid_in  input  NumReq  bit i high: producer i holds at least one complete vector at its FIFO head.
- req_data_in  input  NumReq x WorkingRegs x NBits  head chunk of each producer FIFO (show-ahead).
- req_pop_out  output  NumReq  one-hot pop strobe to the granted producer FIFO.
- act_data_out  output  WorkingRegs x NBits  chunk driven into the activation unit.
- act_result_in  input  WorkingRegs x NBits  activation unit result for act_data_out, same cycle.
- out_data_out  output  WorkingRegs x NBits  activated chunk to the sink.
- out_valid_out  output  1  out_data_out is valid.
- out_ready_in  input  1  sink accepts the beat.
- out_last_out  output  1  beat is the final chunk of the vector.
- out_tag_out  output  $clog2(NumReq)  id of the producer that owns the beat.
- busy_out  output  1  a vector is in flight.

Behaviour:
- ChunksPerVec = ceil(InVecLength/WorkingRegs).
- Chunk counter width: $clog2(ChunksPerVec)+1.
- States are IDLE and BURST.

Reset (asynchronous, rst_n_in low, takes effect immediately):
- State goes to IDLE; chunk_cnt = 0; grant_id = 0.
- rr_ptr = NumReq-1, so producer 0 has highest priority after reset.
- All outputs are 0: req_pop_out, out_valid_out, out_last_out, busy_out, out_tag_out, act_data_out, out_data_out.
- Reset mid-burst abandons the vector. The producer FIFO keeps its unpopped chunks; recovering them is the producer's responsibility.

IDLE:
- If any req_valid_in bit is set, grant the first set bit scanning upward (cyclically) from rr_ptr+1.
- Register grant_id; set rr_ptr = grant_id; clear chunk_cnt; go to BURST next cycle.
- If no bit is set, stay in IDLE.

BURST:
- out_valid_out = 1, busy_out = 1, out_tag_out = grant_id.
- act_data_out = req_data_in[grant_id], combinational mux.
- out_data_out = act_result_in, combinational pass-through.
- Beat accepted when out_valid_out & out_ready_in. On acceptance:
  - req_pop_out[grant_id] = 1 in the same cycle, combinational.
  - chunk_cnt increments.
- out_last_out = (chunk_cnt == ChunksPerVec-1) & out_valid_out.
- Accepted beat with out_last_out: return to IDLE; chunk_cnt = 0.
- out_ready_in low: no pop, no count change, out_data_out must follow the unchanged FIFO head.

General rules:
- Outside BURST: act_data_out = 0, out_valid_out = 0.
- req_valid_in is ignored during BURST. Producers must keep the vector available until its last pop.
- Latency from request to first beat is 2 cycles (IDLE arbitration, then BURST).
- Without the optional feature there is exactly one IDLE bubble between consecutive vectors.
- Vector throughput is ChunksPerVec+1 cycles with out_ready_in held high.
- Boundary cases:
  - Only one requester set: it is granted repeatedly.
  - Requester asserting in the same cycle as a grant to another: waits its round-robin turn.
  - InVecLength <= WorkingRegs: each vector is one beat with out_last_out = 1.

Optional Feature:
- Macro: V_ACT_SCHED_B2B_EN.
- Defined: on the accepted last beat, arbitration runs in that same cycle over req_valid_in, excluding grant_id's bit for this cycle.
  - Uses the same round-robin rule as IDLE.
  - If a winner exists: grant_id and rr_ptr update; stay in BURST with chunk_cnt = 0. No bubble; throughput is ChunksPerVec cycles per vector.
  - If no winner: go to IDLE.
- Not defined: behaviour exactly as in Behaviour (always through IDLE).

Test Plan:
- Defaults; only req_valid_in[2] set, ready always 1 -> 8 beats starting cycle 2 after request, req_pop_out = 4'b0100 on each, out_tag_out = 2, out_last_out only on beat 8, then IDLE.
- All four requesters held valid -> grant order 0,1,2,3,0. Exactly one out_valid_out-low cycle between vectors (macro off); zero such cycles (macro on).
- out_ready_in low for beats 3-5 of a burst -> no pops and data held while low, counter resumes, exactly 8 pops, out_last_out on the 8th accepted beat.
- InVecLength = 20, WorkingRegs = 8 -> 3 beats per vector, out_last_out on beat 3. InVecLength = 8 -> single beat with out_last_out = 1.
- rst_n_in pulsed low after 4 accepted beats of producer 3 -> all outputs 0 asynchronously. After release with producers 0 and 3 valid, producer 0 is granted first.
- Activation stub returns -128 >>> 7 = -1 for input -128 and passes 5 through -> out_data_out lanes equal act_result_in exactly in the accepting cycle.
